pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Successor to the combinational main decoder in the 5-stage RV32I core.
- Decodes the ID-stage opcode and carries the control word through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Inserts bubbles on stall and flush, and decodes jumps and U-type instructions when extensions are enabled.
- Counts illegal opcodes with a saturating counter.

Parameters:
- ALUOP_W, 2: width of the ALU-op field.
- EXT_EN, 1: 1 = decode JAL/JALR/LUI/AUIPC; 0 = treat those opcodes as illegal.
- FLUSH_EX, 0: 1 = flush also clears the EX/MEM entry (branch resolved in MEM); 0 = flush clears only the ID/EX entry.
- CNT_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode_id  in  7  opcode of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  load-use hazard; bubble into ID/EX.
- flush  in  1  taken branch/jump; kill younger instructions.
- ex_alu_op  out  ALUOP_W  ALU op class for EX.
- ex_alu_src  out  1  1 = immediate operand B.
- ex_pc_src_a  out  1  1 = PC as operand A (AUIPC, JAL).
- ex_branch  out  1  conditional branch in EX.
- ex_jump  out  2  00 none, 01 JAL, 10 JALR.
- ex_mem_read  out  1  EX instruction is a load (feeds hazard unit).
- mem_read  out  1  MEM-stage read enable.
- mem_write  out  1  MEM-stage write enable.
- wb_reg_write  out  1  WB register write enable.
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4.
- illegal_ex  out  1  EX instruction had an undecodable opcode.
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes.

Behaviour:
- Decode (combinational, ID), as ALUOp/alu_src/pc_a/branch/jump/mrd/mwr/rw/wb_sel:
  - 0110011 R: 10/0/0/0/00/0/0/1/00
  - 0010011 OP-IMM: 11/1/0/0/00/0/0/1/00
  - 0000011 load: 00/1/0/0/00/1/0/1/01
  - 0100011 store: 00/1/0/0/00/0/1/0/00
  - 1100011 branch: 01/0/0/1/00/0/0/0/00
  - EXT_EN only:
    - 1101111 JAL: 00/1/1/0/01/0/0/1/10
    - 1100111 JALR: 00/1/0/0/10/0/0/1/10
    - 0110111 LUI: 00/1/0/0/00/0/0/1/00
    - 0010111 AUIPC: 00/1/1/0/00/0/0/1/00
  - Any other opcode: all-zero control word, illegal=1.
- Bubble: all-zero control word with illegal=0.
- ID/EX load, in priority order:
  - flush: bubble.
  - stall: bubble.
  - !id_valid: bubble.
  - otherwise: the decoded word.
- Pipeline advance:
  - EX/MEM and MEM/WB advance every cycle; stall never freezes them.
  - FLUSH_EX=1: flush also loads a bubble into EX/MEM that cycle.
  - FLUSH_EX=0: EX/MEM advances normally on flush.
- Latency from opcode_id:
  - EX outputs: 1 cycle.
  - mem_read/mem_write: 2 cycles.
  - wb_reg_write/wb_sel: 3 cycles.
- illegal_cnt:
  - Increments on a clock edge where an illegal entry is loaded into ID/EX. Flushed, stalled or invalid instructions do not count.
  - Saturates at 2^CNT_W-1 with no wrap.
- Reset: every output and all internal registers go to 0 immediately on rst_n low, independent of clk. The first update after release occurs on the next rising clk edge.
- Reset mid-stream discards all in-flight control words; no partial writes.
- stall and flush asserted together: flush semantics apply, one bubble, counter unchanged.

Decomposition:
- Shared package: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), ALUOp codes, wb_sel and jump encodings, and a packed control-word struct.
- One sub-module, ctrl_decode: a purely combinational opcode-to-control-word function with EXT_EN. The top holds the three pipeline registers and the counter.

Test Plan:
- Reset, then R-type 0110011 with id_valid=1 → next cycle ex_alu_op=10, ex_alu_src=0. Two cycles later wb_reg_write=1, wb_sel=00.
- Load 0000011 followed by stall=1 for one cycle → ex_mem_read=1 for one cycle, then an all-zero bubble in EX. mem_read=1 appears exactly once.
- EXT_EN=1, JAL 1101111 → ex_jump=01, ex_pc_src_a=1, then wb_sel=10. With EXT_EN=0 → illegal_ex=1, illegal_cnt=1, all enables 0.
- FLUSH_EX=1: store in EX and branch in ID with flush=1 → next cycle ex_branch=0 and mem_write=0. With FLUSH_EX=0 → mem_write=1.
- CNT_W=2: five consecutive illegal opcodes 0000000 → illegal_cnt sequence 1,2,3,3,3.
- rst_n pulled low mid-stream between clock edges → all outputs 0 before the next edge. illegal_cnt=0 after release.

Source files
------------

// File: rtl/pipelined_control_unit_pkg.sv
// Shared opcode, encoding and control-word definitions for the pipelined
// RV32I control unit and its decoder.
package pipelined_control_unit_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_R      = 2'b10,
      ALU_IMM    = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      JUMP_NONE = 2'b00,
      JUMP_JAL  = 2'b01,
      JUMP_JALR = 2'b10
   } jump_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    pc_src_a;
      logic    branch;
      jump_e   jump;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      wb_sel_e wb_sel;
      logic    illegal;
   } ctrl_word_t;

   typedef struct packed {
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      wb_sel_e wb_sel;
   } ex_mem_t;

   typedef struct packed {
      logic    reg_write;
      wb_sel_e wb_sel;
   } mem_wb_t;

endpackage

// File: rtl/pipelined_control_unit_ctrl_decode.sv
// Purely combinational opcode-to-control-word decoder; extension opcodes
// (JAL/JALR/LUI/AUIPC) decode only when EXT_EN is set.
module pipelined_control_unit_ctrl_decode
   import pipelined_control_unit_pkg::*;
#(
   parameter bit EXT_EN = 1'b1
) (
   input  logic [6:0] opcode,
   output ctrl_word_t word
);

   always_comb begin
      // NOTE: full default first so every path assigns every field; no latch.
      word         = '0;
      word.illegal = 1'b1;
      case (opcode)
         OP_R: begin
            word.illegal   = 1'b0;
            word.alu_op    = ALU_R;
            word.reg_write = 1'b1;
         end
         OP_IMM: begin
            word.illegal   = 1'b0;
            word.alu_op    = ALU_IMM;
            word.alu_src   = 1'b1;
            word.reg_write = 1'b1;
         end
         OP_LOAD: begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.mem_read  = 1'b1;
            word.reg_write = 1'b1;
            word.wb_sel    = WB_MEM;
         end
         OP_STORE: begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            word.illegal = 1'b0;
            word.alu_op  = ALU_BRANCH;
            word.branch  = 1'b1;
         end
         OP_JAL: if (EXT_EN) begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.pc_src_a  = 1'b1;
            word.jump      = JUMP_JAL;
            word.reg_write = 1'b1;
            word.wb_sel    = WB_PC4;
         end
         OP_JALR: if (EXT_EN) begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.jump      = JUMP_JALR;
            word.reg_write = 1'b1;
            word.wb_sel    = WB_PC4;
         end
         OP_LUI: if (EXT_EN) begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.reg_write = 1'b1;
         end
         OP_AUIPC: if (EXT_EN) begin
            word.illegal   = 1'b0;
            word.alu_src   = 1'b1;
            word.pc_src_a  = 1'b1;
            word.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes in ID and carries the control word through
// ID/EX, EX/MEM and MEM/WB, with bubbles and a saturating illegal counter.
module pipelined_control_unit
   import pipelined_control_unit_pkg::*;
#(
   parameter int unsigned ALUOP_W  = 2,
   parameter bit          EXT_EN   = 1'b1,
   parameter bit          FLUSH_EX = 1'b0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode_id,
   input  logic               id_valid,
   input  logic               stall,
   input  logic               flush,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alu_src,
   output logic               ex_pc_src_a,
   output logic               ex_branch,
   output logic [1:0]         ex_jump,
   output logic               ex_mem_read,
   output logic               mem_read,
   output logic               mem_write,
   output logic               wb_reg_write,
   output logic [1:0]         wb_sel,
   output logic               illegal_ex,
   output logic [CNT_W-1:0]   illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ctrl_word_t       dec_word;
   ctrl_word_t       id_ex_d,  id_ex_q;
   ex_mem_t          ex_mem_d, ex_mem_q;
   mem_wb_t          mem_wb_d, mem_wb_q;
   logic [CNT_W-1:0] cnt_d,    cnt_q;

   pipelined_control_unit_ctrl_decode #(
      .EXT_EN (EXT_EN)
   ) u_ctrl_decode (
      .opcode (opcode_id),
      .word   (dec_word)
   );

   always_comb begin
      id_ex_d = dec_word;
      if (flush || stall || !id_valid) id_ex_d = '0;

      ex_mem_d.mem_read  = id_ex_q.mem_read;
      ex_mem_d.mem_write = id_ex_q.mem_write;
      ex_mem_d.reg_write = id_ex_q.reg_write;
      ex_mem_d.wb_sel    = id_ex_q.wb_sel;
      // With the branch resolved in MEM, the instruction leaving EX is also wrong-path.
      if (FLUSH_EX && flush) ex_mem_d = '0;

      mem_wb_d.reg_write = ex_mem_q.reg_write;
      mem_wb_d.wb_sel    = ex_mem_q.wb_sel;

      cnt_d = cnt_q;
      if (id_ex_d.illegal && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
   end

   // NOTE: non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
         cnt_q    <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ex_alu_op    = ALUOP_W'(id_ex_q.alu_op);
   assign ex_alu_src   = id_ex_q.alu_src;
   assign ex_pc_src_a  = id_ex_q.pc_src_a;
   assign ex_branch    = id_ex_q.branch;
   assign ex_jump      = id_ex_q.jump;
   assign ex_mem_read  = id_ex_q.mem_read;
   assign illegal_ex   = id_ex_q.illegal;
   assign mem_read     = ex_mem_q.mem_read;
   assign mem_write    = ex_mem_q.mem_write;
   assign wb_reg_write = mem_wb_q.reg_write;
   assign wb_sel       = mem_wb_q.wb_sel;
   assign illegal_cnt  = cnt_q;

endmodule
